// File: rtl/alu_mc.sv
// Multi-cycle XLEN-generic ALU with valid/ready handshakes.
// Shifts iterate SHIFT_STEP bits per cycle; the result is registered.
package alu_mc_pkg;
  localparam int ALU_CTRL_WIDTH = 5;
  typedef logic [ALU_CTRL_WIDTH-1:0] aluctl_t;
  localparam aluctl_t ALU_CTRL_ADD   = 5'd0;
  localparam aluctl_t ALU_CTRL_SUB   = 5'd1;
  localparam aluctl_t ALU_CTRL_XOR   = 5'd2;
  localparam aluctl_t ALU_CTRL_OR    = 5'd3;
  localparam aluctl_t ALU_CTRL_AND   = 5'd4;
  localparam aluctl_t ALU_CTRL_SLL   = 5'd5;
  localparam aluctl_t ALU_CTRL_SRL   = 5'd6;
  localparam aluctl_t ALU_CTRL_SRA   = 5'd7;
  localparam aluctl_t ALU_CTRL_SLT   = 5'd8;
  localparam aluctl_t ALU_CTRL_SLTU  = 5'd9;
  localparam aluctl_t ALU_CTRL_AUIPC = 5'd10;
  localparam aluctl_t ALU_CTRL_LUI   = 5'd11;
  localparam aluctl_t ALU_CTRL_BEQ   = 5'd12;
  localparam aluctl_t ALU_CTRL_BNE   = 5'd13;
  localparam aluctl_t ALU_CTRL_BLT   = 5'd14;
  localparam aluctl_t ALU_CTRL_BGE   = 5'd15;
  localparam aluctl_t ALU_CTRL_BLTU  = 5'd16;
  localparam aluctl_t ALU_CTRL_BGEU  = 5'd17;
  localparam aluctl_t ALU_CTRL_MIN   = 5'd18;
  localparam aluctl_t ALU_CTRL_MAX   = 5'd19;
  localparam aluctl_t ALU_CTRL_MINU  = 5'd20;
  localparam aluctl_t ALU_CTRL_MAXU  = 5'd21;
endpackage

module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [XLEN-1:0]           a,
  input  logic [XLEN-1:0]           b,
  input  logic [ALU_CTRL_WIDTH-1:0] alucontrol,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [XLEN-1:0]           result,
  output logic                      zero
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEPW = (SW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] acc, acc_n;
  logic [XLEN-1:0] res, res_n;
  logic [SW-1:0]   rem, rem_n;
  aluctl_t         op, op_n;
  logic [SW:0]     step;
  logic [XLEN-1:0] shifted;

  function automatic logic is_shift(input aluctl_t c);
    return (c == ALU_CTRL_SLL) || (c == ALU_CTRL_SRL) ||
           (c == ALU_CTRL_SRA);
  endfunction

  function automatic logic [XLEN-1:0] calc(
    input aluctl_t         c,
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y
  );
    logic lts, ltu;
    lts = $signed(x) < $signed(y);
    ltu = x < y;
    unique case (c)
      ALU_CTRL_ADD,
      ALU_CTRL_AUIPC: return x + y;
      ALU_CTRL_SUB:   return x - y;
      ALU_CTRL_XOR:   return x ^ y;
      ALU_CTRL_OR:    return x | y;
      ALU_CTRL_AND:   return x & y;
      ALU_CTRL_LUI:   return y;
      ALU_CTRL_SLT,
      ALU_CTRL_BLT:   return XLEN'(lts);
      ALU_CTRL_SLTU,
      ALU_CTRL_BLTU:  return XLEN'(ltu);
      ALU_CTRL_BEQ:   return XLEN'(x == y);
      ALU_CTRL_BNE:   return XLEN'(x != y);
      ALU_CTRL_BGE:   return XLEN'(!lts);
      ALU_CTRL_BGEU:  return XLEN'(!ltu);
      ALU_CTRL_MIN:   return (lts || x == y) ? x : y;
      ALU_CTRL_MAX:   return lts ? y : x;
      ALU_CTRL_MINU:  return (ltu || x == y) ? x : y;
      ALU_CTRL_MAXU:  return ltu ? y : x;
      default:        return '0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    op_n    = op;
    res_n   = res;
    step    = '0;
    shifted = acc;
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
    unique case (state)
      IDLE: begin
        if (valid_i) begin
          op_n = alucontrol;
          if (is_shift(alucontrol)) begin
            acc_n = a;
            rem_n = b[SW-1:0];
            if (b[SW-1:0] == '0) begin
              res_n   = a;
              state_n = DONE;
            end else begin
              state_n = SHIFT;
            end
          end else begin
            res_n   = calc(alucontrol, a, b);
            state_n = DONE;
          end
        end
      end
      SHIFT: begin
        step = ({1'b0, rem} < STEPW) ? {1'b0, rem} : STEPW;
        unique case (1'b1)
          op == ALU_CTRL_SLL: shifted = acc << step;
          op == ALU_CTRL_SRA: shifted = $signed(acc) >>> step;
          default:            shifted = acc >> step;
        endcase
        acc_n = shifted;
        rem_n = rem - step[SW-1:0];
        if (rem == step[SW-1:0]) begin
          res_n   = shifted;
          state_n = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      op    <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      rem   <= rem_n;
      op    <= op_n;
      res   <= res_n;
    end
  end

  assign result = res;
  assign zero   = (res == '0);

endmodule
